// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types and constants for fetch and hazard logic
package mips_pkg;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10
   } pc_src_t;

   // sll $0,$0,0
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_JUMP = 6'b000010;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory fetch port between if_stage and imem
interface if_stage_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   modport master (
      output imem_addr,
      input  imem_rdata
   );

   modport slave (
      input  imem_addr,
      output imem_rdata
   );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register; stall holds, flush inserts a bubble
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        write_en,
   input  logic        flush,
   input  logic [31:0] fetch_inst,
   input  logic [31:0] fetch_pc_plus4,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc_plus4,
   output logic        id_valid
);

   // A stall outranks a flush so the branch re-evaluates once the stall clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_inst     <= NOP_INST;
         id_pc_plus4 <= 32'h0;
         id_valid    <= 1'b0;
      end else if (!write_en) begin
         id_inst     <= id_inst;
         id_pc_plus4 <= id_pc_plus4;
         id_valid    <= id_valid;
      end else if (flush) begin
         id_inst     <= NOP_INST;
         id_pc_plus4 <= 32'h0;
         id_valid    <= 1'b0;
      end else begin
         id_inst     <= fetch_inst;
         id_pc_plus4 <= fetch_pc_plus4;
         id_valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - fetch stage: PC, next-PC select, IF/ID register
// Optional performance counters enabled by defining IF_PERF_CNT_EN.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pc_ld,
   input  logic          IF_ID_write,
   input  logic          flush,
   input  logic [1:0]    pc_src,
   input  logic [31:0]   branch_target,
   input  logic [25:0]   jump_index,
   if_stage_if.master    imem,
   output logic [31:0]   pc,
   output logic [31:0]   IF_ID_inst,
   output logic [31:0]   IF_ID_pc_plus4,
   output logic          IF_ID_valid,
   output logic [31:0]   stall_cnt,
   output logic [31:0]   flush_cnt
);

   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;

   assign pc_plus4       = pc_q + 32'd4;
   assign pc             = pc_q;
   assign imem.imem_addr = pc_q;

   // Jump region comes from the jump's own PC+4, which sits in IF/ID while it decodes.
   always_comb begin
      next_pc = pc_plus4;
      case (pc_src)
         PC_BRANCH: next_pc = branch_target;
         PC_JUMP:   next_pc = {IF_ID_pc_plus4[31:28], jump_index, 2'b00};
         default:   next_pc = pc_plus4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (pc_ld) begin
         pc_q <= next_pc;
      end
   end

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk            (clk),
      .rst            (rst),
      .write_en       (IF_ID_write),
      .flush          (flush),
      .fetch_inst     (imem.imem_rdata),
      .fetch_pc_plus4 (pc_plus4),
      .id_inst        (IF_ID_inst),
      .id_pc_plus4    (IF_ID_pc_plus4),
      .id_valid       (IF_ID_valid)
   );

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   // Only flushes that actually reach IF/ID are counted; both counters saturate.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 32'h0;
         flush_q <= 32'h0;
      end else begin
         if (!pc_ld && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
         end
         if (flush && IF_ID_write && flush_q != 32'hFFFF_FFFF) begin
            flush_q <= flush_q + 32'd1;
         end
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = 32'h0;
   assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_ld;
   logic        IF_ID_write;
   logic        flush;
   logic [1:0]  pc_src;
   logic [31:0] branch_target;
   logic [25:0] jump_index;
   logic [31:0] pc;
   logic [31:0] IF_ID_inst;
   logic [31:0] IF_ID_pc_plus4;
   logic        IF_ID_valid;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   if_stage_if imem ();

   assign imem.imem_rdata = imem.imem_addr + 32'h100;

   always #5 clk = ~clk;

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .pc_ld          (pc_ld),
      .IF_ID_write    (IF_ID_write),
      .flush          (flush),
      .pc_src         (pc_src),
      .branch_target  (branch_target),
      .jump_index     (jump_index),
      .imem           (imem.master),
      .pc             (pc),
      .IF_ID_inst     (IF_ID_inst),
      .IF_ID_pc_plus4 (IF_ID_pc_plus4),
      .IF_ID_valid    (IF_ID_valid),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ld, input logic wr, input logic fl,
                        input logic [1:0] src, input logic [31:0] tgt, input logic [25:0] idx);
      pc_ld = ld;
      IF_ID_write = wr;
      flush = fl;
      pc_src = src;
      branch_target = tgt;
      jump_index = idx;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                             input logic [31:0] e_p4, input logic e_valid);
      check({tag, ".pc"}, pc, e_pc);
      check({tag, ".inst"}, IF_ID_inst, e_inst);
      check({tag, ".pc_plus4"}, IF_ID_pc_plus4, e_p4);
      check({tag, ".valid"}, {31'h0, IF_ID_valid}, {31'h0, e_valid});
   endtask

   task automatic check_cnt(input string tag, input logic [31:0] e_stall, input logic [31:0] e_flush);
`ifdef IF_PERF_CNT_EN
      check({tag, ".stall_cnt"}, stall_cnt, e_stall);
      check({tag, ".flush_cnt"}, flush_cnt, e_flush);
`else
      check({tag, ".stall_cnt"}, stall_cnt, 32'h0);
      check({tag, ".flush_cnt"}, flush_cnt, 32'h0);
`endif
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b0, PC_SEQ, 32'h0, 26'h0);
      step();
      step();
      check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      check("reset.imem_addr", imem.imem_addr, 32'h0);
      check_cnt("reset", 32'h0, 32'h0);

      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         check_ifid($sformatf("seq%0d", i), 32'(4 * i), 32'(4 * (i - 1) + 32'h100),
                    32'(4 * i), 1'b1);
      end

      drive(1'b0, 1'b0, 1'b0, PC_BRANCH, 32'h200, 26'h0);
      step();
      step();
      check_ifid("stall", 32'h10, 32'h10C, 32'h10, 1'b1);
      check_cnt("stall", 32'd2, 32'd0);

      drive(1'b1, 1'b1, 1'b0, PC_SEQ, 32'h0, 26'h0);
      step();
      check_ifid("resume", 32'h14, 32'h110, 32'h14, 1'b1);

      drive(1'b1, 1'b1, 1'b1, PC_BRANCH, 32'h40, 26'h0);
      step();
      check_ifid("branch", 32'h40, 32'h0, 32'h0, 1'b0);
      check_cnt("branch", 32'd2, 32'd1);
      drive(1'b1, 1'b1, 1'b0, PC_SEQ, 32'h0, 26'h0);
      step();
      check_ifid("branch_tgt", 32'h44, 32'h140, 32'h44, 1'b1);

      drive(1'b1, 1'b1, 1'b1, PC_BRANCH, 32'h1000_0004, 26'h0);
      step();
      drive(1'b1, 1'b1, 1'b0, PC_SEQ, 32'h0, 26'h0);
      step();
      check_ifid("pre_jump", 32'h1000_0008, 32'h1000_0104, 32'h1000_0008, 1'b1);
      drive(1'b1, 1'b1, 1'b1, PC_JUMP, 32'h0, 26'h10);
      step();
      check_ifid("jump", 32'h1000_0040, 32'h0, 32'h0, 1'b0);
      check_cnt("jump", 32'd2, 32'd3);

      drive(1'b1, 1'b1, 1'b0, PC_SEQ, 32'h0, 26'h0);
      step();
      check_ifid("jump_tgt", 32'h1000_0044, 32'h1000_0140, 32'h1000_0044, 1'b1);

      drive(1'b0, 1'b0, 1'b1, PC_BRANCH, 32'h80, 26'h0);
      step();
      check_ifid("stall_flush", 32'h1000_0044, 32'h1000_0140, 32'h1000_0044, 1'b1);
      check_cnt("stall_flush", 32'd3, 32'd3);

      drive(1'b1, 1'b1, 1'b1, PC_BRANCH, 32'hFFFF_FFFC, 26'h0);
      step();
      drive(1'b1, 1'b1, 1'b0, PC_SEQ, 32'h0, 26'h0);
      step();
      check_ifid("wrap", 32'h0, 32'h0000_00FC, 32'h0, 1'b1);

      drive(1'b1, 1'b1, 1'b0, 2'b11, 32'h80, 26'h3);
      step();
      check_ifid("src11", 32'h4, 32'h100, 32'h4, 1'b1);

      rst = 1'b1;
      step();
      step();
      check_ifid("midreset", 32'h0, 32'h0, 32'h0, 1'b0);
      check_cnt("midreset", 32'h0, 32'h0);
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, PC_SEQ, 32'h0, 26'h0);
      step();
      check_ifid("restart", 32'h4, 32'h100, 32'h4, 1'b1);

`ifdef IF_PERF_CNT_EN
      force dut.stall_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_q;
      drive(1'b0, 1'b0, 1'b0, PC_SEQ, 32'h0, 26'h0);
      step();
      step();
      step();
      check("saturate.stall_cnt", stall_cnt, 32'hFFFF_FFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
